// File: rtl/ram_burst_reader.sv
// ram_burst_reader: burst read initiator for the fixed-latency RAM read port (port B).
// Takes a start address and a beat count, issues one read per cycle, lines the
// returned words up with a latency pipe, and hands them to a valid/ready stream
// through a small FIFO. A read is issued only while the FIFO plus the reads in
// flight still leave room, so a push never meets a full FIFO.
// Optional feature: define BURST_RD_STATS_EN to add the beat_cnt/stall_cnt counters.

module ram_burst_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned MEM_DEPTH  = 1024,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned RD_LATENCY = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  ram_ren,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
`ifdef BURST_RD_STATS_EN
    ,
    output logic [31:0]           beat_cnt,
    output logic [31:0]           stall_cnt
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1);

    if (RD_LATENCY < 1) begin : g_lat_check
        $error("RD_LATENCY must be at least 1");
    end
    if (FIFO_DEPTH < RD_LATENCY + 1) begin : g_depth_check
        $error("FIFO_DEPTH must be at least RD_LATENCY+1");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH:0]    remaining_q, remaining_d;
    logic                  ready_en_q;

    logic [RD_LATENCY-1:0] pipe_valid_q, pipe_last_q;

    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic                  fifo_last_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      fifo_count_q;

    logic [CNT_W-1:0]      inflight;
    logic                  credit_ok;
    logic                  fifo_empty;
    logic                  push, pop;
    logic                  issue, issue_last, stall;

    // Reads in flight: number of valid slots in the latency pipe.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CNT_W'(pipe_valid_q[i]);
        end
    end

    assign fifo_empty = (fifo_count_q == '0);
    assign credit_ok  = (fifo_count_q + inflight) < CNT_W'(FIFO_DEPTH);
    assign push       = pipe_valid_q[RD_LATENCY-1];
    assign pop        = !fifo_empty && out_ready;
    assign issue_last = issue && (remaining_q == (LEN_WIDTH+1)'(1));

    // Burst FSM next-state, read issue and address/beat bookkeeping.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        issue       = 1'b0;
        stall       = 1'b0;
        cmd_ready   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // ready_en_q keeps cmd_ready low until the cycle after reset is released
                cmd_ready = ready_en_q && fifo_empty;
                if (cmd_valid && cmd_ready) begin
                    cur_addr_d  = cmd_addr;
                    remaining_d = {1'b0, cmd_len} + (LEN_WIDTH+1)'(1);
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (credit_ok) begin
                    issue       = 1'b1;
                    cur_addr_d  = (cur_addr_q == ADDR_WIDTH'(MEM_DEPTH - 1)) ?
                                  '0 : cur_addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - (LEN_WIDTH+1)'(1);
                    if (remaining_q == (LEN_WIDTH+1)'(1)) begin
                        state_d = StDrain;
                    end
                end else begin
                    stall = 1'b1;
                end
            end
            StDrain: begin
                // Leave on the edge that pops the final beat so busy drops with it
                if (inflight == '0 &&
                    (fifo_empty || (fifo_count_q == CNT_W'(1) && pop))) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign ram_ren   = issue;
    assign ram_addr  = issue ? cur_addr_q : '0;
    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign out_last  = out_valid ? fifo_last_q[rd_ptr_q] : 1'b0;
    assign busy      = (state_q != StIdle) || !fifo_empty;

    // FSM and burst registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            ready_en_q  <= 1'b1;
        end
    end

    // Latency pipe, shifted every cycle so its tap lines up with ram_rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid_q <= '0;
            pipe_last_q  <= '0;
        end else begin
            pipe_valid_q[0] <= issue;
            pipe_last_q[0]  <= issue_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_last_q[i]  <= pipe_last_q[i-1];
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            fifo_count_q <= fifo_count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= ram_rdata;
            fifo_last_q[wr_ptr_q] <= pipe_last_q[RD_LATENCY-1];
        end
    end

`ifdef BURST_RD_STATS_EN
    logic [31:0] beat_cnt_q, stall_cnt_q;

    // Free-running statistics, both wrap modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            beat_cnt_q  <= beat_cnt_q + 32'(pop);
            stall_cnt_q <= stall_cnt_q + 32'(stall);
        end
    end

    assign beat_cnt  = beat_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader: directed bench for ram_burst_reader with a 3-cycle RAM model.
// Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.

module tb_ram_burst_reader;

    logic        clk, rst;
    logic        cmd_valid, cmd_ready;
    logic [9:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic        ram_ren;
    logic [9:0]  ram_addr;
    logic [31:0] ram_rdata;
    logic        out_valid, out_ready, out_last, busy;
    logic [31:0] out_data;
`ifdef BURST_RD_STATS_EN
    logic [31:0] beat_cnt, stall_cnt;
`endif

    ram_burst_reader dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .ram_ren   (ram_ren),
        .ram_addr  (ram_addr),
        .ram_rdata (ram_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
`ifdef BURST_RD_STATS_EN
        ,
        .beat_cnt  (beat_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vec_count = 0;
    int miss_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int unsigned a);
        return 32'hA500_0000 ^ (a * 32'h0001_0107);
    endfunction

    // RAM model: 3-cycle read latency.
    logic [31:0] mem [1024];
    logic [31:0] rp0, rp1, rp2;
    initial for (int i = 0; i < 1024; i++) mem[i] = word_of(i);
    always @(posedge clk) begin
        rp0 <= ram_ren ? mem[ram_addr] : 32'hDEAD_BEEF;
        rp1 <= rp0;
        rp2 <= rp1;
    end
    assign ram_rdata = rp2;

    // Monitor: accepted beats, issued addresses, hold stability under backpressure.
    logic [31:0] got_data[$];
    logic        got_last[$];
    logic [9:0]  rd_log[$];
    logic        hold_valid = 1'b0;
    logic [31:0] hold_data;
    logic        hold_last;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
            end
            if (ram_ren) rd_log.push_back(ram_addr);
            if (hold_valid)
                check("stall_hold", {31'd0, out_valid, out_last, out_data},
                      {31'd0, 1'b1, hold_last, hold_data});
        end
        hold_valid = !rst && out_valid && !out_ready;
        hold_data  = out_data;
        hold_last  = out_last;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        got_data.delete();
        got_last.delete();
        rd_log.delete();
    endtask

    // Present a command and return just after the accepting edge.
    task automatic send_cmd(input logic [9:0] a, input logic [7:0] l);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) check("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit toggle, input int budget, output int cycles);
        cycles = 0;
        while (busy && cycles < budget) begin
            if (toggle) out_ready = ~out_ready;
            tick();
            cycles++;
        end
        if (cycles == budget) check("busy_timeout", 64'(busy), 64'd0);
    endtask

    task automatic check_beats(input string tag, input logic [9:0] a, input int exp_beats);
        check({tag, "_beats"}, 64'(got_data.size()), 64'(exp_beats));
        for (int i = 0; i < got_data.size() && i < exp_beats; i++) begin
            check($sformatf("%s_data%0d", tag, i), 64'(got_data[i]),
                  64'(word_of((int'(a) + i) % 1024)));
            check($sformatf("%s_last%0d", tag, i), 64'(got_last[i]), 64'(i == exp_beats - 1));
        end
    endtask

    task automatic run_burst(input logic [9:0] a, input logic [7:0] l, input bit toggle,
                             input int exp_beats, input logic [9:0] exp_last_addr,
                             input string tag);
        int cyc;
        clear_logs();
        out_ready = 1'b1;
        send_cmd(a, l);
        wait_idle(toggle, 2000, cyc);
        out_ready = 1'b1;
        tick();
        check_beats(tag, a, exp_beats);
        check({tag, "_reads"}, 64'(rd_log.size()), 64'(exp_beats));
        if (rd_log.size() > 0) check({tag, "_last_addr"}, 64'(rd_log[$]), 64'(exp_last_addr));
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
    endtask

    typedef struct {
        logic [9:0] addr;
        logic [7:0] len;
        bit         toggle;
        int         exp_beats;
        logic [9:0] exp_last_addr;
        string      tag;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int cyc;

        vecs[0] = '{10'h010, 8'd3,  1'b0, 4,  10'h013, "t_basic"};
        vecs[1] = '{10'h3FE, 8'd3,  1'b0, 4,  10'h001, "t_wrap"};
        vecs[2] = '{10'h3FF, 8'd0,  1'b0, 1,  10'h3FF, "t_single_top"};
        vecs[3] = '{10'h100, 8'd7,  1'b1, 8,  10'h107, "t_toggle"};
        vecs[4] = '{10'h3FC, 8'd15, 1'b1, 16, 10'h00B, "t_toggle_wrap"};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        out_ready = 1'b1;
        tick(); tick(); tick();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_ram_ren", 64'(ram_ren), 64'd0);
        check("rst_ram_addr", 64'(ram_addr), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        check("rst_release_ready_low", 64'(cmd_ready), 64'd0);
        tick();
        check("rst_release_ready_high", 64'(cmd_ready), 64'd1);

        // Test 1: address sequence, first-beat latency, busy falls with the last pop.
        clear_logs();
        send_cmd(10'h010, 8'd3);
        check("t1_busy_after_accept", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_ren%0d", i), 64'(ram_ren), 64'd1);
            check($sformatf("t1_addr%0d", i), 64'(ram_addr), 64'(10'h010 + i));
            check($sformatf("t1_early_valid%0d", i), 64'(out_valid), 64'd0);
            tick();
        end
        check("t1_ren_done", 64'(ram_ren), 64'd0);
        check("t1_first_valid", 64'(out_valid), 64'd1);
        check("t1_first_data", 64'(out_data), 64'(word_of(10'h010)));
        wait_idle(1'b0, 100, cyc);
        check("t1_busy_fall_cycles", 64'(cyc), 64'd4);
        tick();
        check_beats("t1", 10'h010, 4);

        // Test 3: backpressure limits reads to the FIFO depth, nothing is lost.
        clear_logs();
        out_ready = 1'b0;
        send_cmd(10'h200, 8'd15);
        for (int i = 0; i < 12; i++) tick();
        check("t3_reads_stalled", 64'(rd_log.size()), 64'd4);
        check("t3_ren_low", 64'(ram_ren), 64'd0);
        check("t3_head_valid", 64'(out_valid), 64'd1);
        check("t3_head_data", 64'(out_data), 64'(word_of(10'h200)));
        out_ready = 1'b1;
        wait_idle(1'b0, 500, cyc);
        tick();
        check_beats("t3", 10'h200, 16);
        check("t3_reads_total", 64'(rd_log.size()), 64'd16);
`ifdef BURST_RD_STATS_EN
        check("t6_beat_cnt", 64'(beat_cnt), 64'd20);
        check("t6_stall_cnt_nonzero", 64'(stall_cnt != 0), 64'd1);
`endif

        // Table: wrap, single beat at the top address, toggled backpressure.
        for (int v = 0; v < 5; v++) begin
            run_burst(vecs[v].addr, vecs[v].len, vecs[v].toggle, vecs[v].exp_beats,
                      vecs[v].exp_last_addr, vecs[v].tag);
        end

        // Test 5: reset two cycles into a burst, then a fresh single-beat burst.
        clear_logs();
        out_ready = 1'b1;
        send_cmd(10'h300, 8'd7);
        tick(); tick();
        rst = 1'b1;
        tick();
        check("t5_valid_after_rst", 64'(out_valid), 64'd0);
        check("t5_busy_after_rst", 64'(busy), 64'd0);
        check("t5_ren_after_rst", 64'(ram_ren), 64'd0);
        rst = 1'b0;
        clear_logs();
        for (int i = 0; i < 10; i++) tick();
        check("t5_no_stale_beat", 64'(got_data.size()), 64'd0);
        check("t5_idle_valid", 64'(out_valid), 64'd0);
        run_burst(10'h020, 8'd0, 1'b0, 1, 10'h020, "t5_new");

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
